// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit, 8-register MIPS core front end.
// Instruction field positions, the NOP encoding and the fetch-stage action type.
package mips_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 9;
    localparam int RT_MSB     = 8;
    localparam int RT_LSB     = 6;

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_BRANCH
    } fetch_act_e;

    // A redirect squashes the stall request: the stalled instruction is on the wrong path.
    function automatic fetch_act_e pick_action(input logic branch_taken, input logic stall);
        if (branch_taken)
            return ACT_BRANCH;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch/IF-ID stage and its environment
// (instruction memory, hazard unit, EX-stage redirect, decode consumers).
interface if_id_stage_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
);
    import mips_pkg::*;

    logic [PC_W-1:0]       imem_addr;
    logic [INSTR_W-1:0]    imem_rdata;
    logic                  DataHazard;
    logic                  branch_taken;
    logic [PC_W-1:0]       branch_target;
    logic [INSTR_W-1:0]    instr_ID;
    logic [PC_W-1:0]       pc_plus_ID;
    logic                  valid_ID;
    logic [REG_ADDR_W-1:0] rsaddr_ID;
    logic [REG_ADDR_W-1:0] rtaddr_ID;
    logic                  bubble_EX;
    logic [CNT_W-1:0]      stall_cnt;
    logic                  hazard_err;

    modport master (
        output imem_addr, instr_ID, pc_plus_ID, valid_ID, rsaddr_ID, rtaddr_ID,
               bubble_EX, stall_cnt, hazard_err,
        input  imem_rdata, DataHazard, branch_taken, branch_target
    );

    modport slave (
        input  imem_addr, instr_ID, pc_plus_ID, valid_ID, rsaddr_ID, rtaddr_ID,
               bubble_EX, stall_cnt, hazard_err,
        output imem_rdata, DataHazard, branch_taken, branch_target
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter with load (redirect), hold (stall) and increment (advance).
// pc_inc is the sequential successor, shared with the IF/ID register.
module pc_reg #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            hold,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc
);

    // Wraps modulo 2^PC_W by construction.
    assign pc_inc = pc + PC_W'(PC_INC);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (!hold)
            pc <= pc_inc;
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC, instruction latch, rs/rt decode for the
// hazard unit, stall freeze with ID/EX bubble, branch flush, stall statistics and alarm.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              INSTR_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              PC_INC    = 2,
    parameter int              CNT_W     = 16,
    parameter int              MAX_STALL = 2
) (
    input logic           clk,
    input logic           rst,
    if_id_stage_if.master bus
);

    localparam int CONS_W = $clog2(MAX_STALL + 2);

    logic              stall;
    fetch_act_e        act;
    logic [PC_W-1:0]   pc_inc;
    logic [CONS_W-1:0] consec;
    logic [CONS_W:0]   consec_next;

    // A stall on an empty slot would only waste a cycle, so invalid slots never stall.
    assign stall         = bus.DataHazard & bus.valid_ID & ~bus.branch_taken;
    assign bus.bubble_EX = stall;

    always_comb begin
        act = pick_action(bus.branch_taken, stall);
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (act == ACT_BRANCH),
        .load_val (bus.branch_target),
        .hold     (act == ACT_STALL),
        .pc       (bus.imem_addr),
        .pc_inc   (pc_inc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.instr_ID   <= INSTR_W'(NOP);
            bus.pc_plus_ID <= '0;
            bus.valid_ID   <= 1'b0;
        end else begin
            unique case (act)
                ACT_BRANCH: begin
                    bus.instr_ID   <= INSTR_W'(NOP);
                    bus.pc_plus_ID <= '0;
                    bus.valid_ID   <= 1'b0;
                end
                ACT_STALL: ;
                default: begin
                    bus.instr_ID   <= bus.imem_rdata;
                    bus.pc_plus_ID <= pc_inc;
                    bus.valid_ID   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rsaddr_ID = bus.valid_ID ? bus.instr_ID[RS_MSB:RS_LSB] : '0;
    assign bus.rtaddr_ID = bus.valid_ID ? bus.instr_ID[RT_MSB:RT_LSB] : '0;

    // One extra bit so the run-length compare is exact even when consec is saturated.
    assign consec_next = {1'b0, consec} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt  <= '0;
            bus.hazard_err <= 1'b0;
            consec         <= '0;
        end else if (stall) begin
            if (bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (consec != '1)
                consec <= consec + 1'b1;
            if (consec_next > (CONS_W + 1)'(MAX_STALL))
                bus.hazard_err <= 1'b1;
        end else begin
            consec <= '0;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a per-cycle vector table for fetch/stall/branch,
// then hand-written sequences for decode, stuck-stall alarm, PC wrap and reset mid-stall.
module tb_if_id_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;
    logic        override_en;
    logic [15:0] override_val;

    int checks = 0;
    int errors = 0;

    if_id_stage_if #(.PC_W(16), .INSTR_W(16), .CNT_W(16)) bus ();

    if_id_stage #(
        .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(2), .CNT_W(16), .MAX_STALL(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: async read returning 16'h1000 + address unless overridden.
    always_comb begin
        bus.imem_rdata = override_en ? override_val : (16'h1000 + bus.imem_addr);
    end

    typedef struct {
        logic        rst;
        logic        dh;
        logic        br;
        logic [15:0] tgt;
        logic        exp_bubble;
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
        logic [15:0] exp_pp;
        logic        exp_valid;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                               input logic [15:0] pp, input logic valid, input logic [15:0] cnt,
                               input logic err);
        check({tag, ".imem_addr"},  32'(bus.imem_addr),  32'(addr));
        check({tag, ".instr_ID"},   32'(bus.instr_ID),   32'(instr));
        check({tag, ".pc_plus_ID"}, 32'(bus.pc_plus_ID), 32'(pp));
        check({tag, ".valid_ID"},   32'(bus.valid_ID),   32'(valid));
        check({tag, ".stall_cnt"},  32'(bus.stall_cnt),  32'(cnt));
        check({tag, ".hazard_err"}, 32'(bus.hazard_err), 32'(err));
    endtask

    initial begin
        rst               = 1'b1;
        bus.DataHazard    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0000;
        override_en       = 1'b0;
        override_val      = 16'h0000;

        //           rst   dh    br    tgt      bub   addr     instr    pp       val   cnt  err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0002, 16'h1000, 16'h0002, 1'b1, 16'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0004, 16'h1002, 16'h0004, 1'b1, 16'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0006, 16'h1004, 16'h0006, 1'b1, 16'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0008, 16'h1006, 16'h0008, 1'b1, 16'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0,   1'b1, 16'h0008, 16'h1006, 16'h0008, 1'b1, 16'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0,   1'b1, 16'h0008, 16'h1006, 16'h0008, 1'b1, 16'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h000A, 16'h1008, 16'h000A, 1'b1, 16'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h40,  1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 16'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0,   1'b0, 16'h0042, 16'h1040, 16'h0042, 1'b1, 16'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0,   1'b0, 16'h0044, 16'h1042, 16'h0044, 1'b1, 16'd2, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst               = vecs[i].rst;
            bus.DataHazard    = vecs[i].dh;
            bus.branch_taken  = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            #1;
            check($sformatf("vec%0d.bubble_EX", i), 32'(bus.bubble_EX), 32'(vecs[i].exp_bubble));
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_instr,
                        vecs[i].exp_pp, vecs[i].exp_valid, vecs[i].exp_cnt, vecs[i].exp_err);
            if (i == 8) begin
                check("flush.rsaddr_ID", 32'(bus.rsaddr_ID), 32'd0);
                check("flush.rtaddr_ID", 32'(bus.rtaddr_ID), 32'd0);
            end
        end
        bus.DataHazard   = 1'b0;
        bus.branch_taken = 1'b0;

        // Decode of 16'h0A40 and a two-cycle freeze.
        override_en  = 1'b1;
        override_val = 16'h0A40;
        tick();
        check_state("dec", 16'h0046, 16'h0A40, 16'h0046, 1'b1, 16'd2, 1'b0);
        check("dec.rsaddr_ID", 32'(bus.rsaddr_ID), 32'd5);
        check("dec.rtaddr_ID", 32'(bus.rtaddr_ID), 32'd1);
        override_en    = 1'b0;
        bus.DataHazard = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            #1;
            check($sformatf("stall%0d.bubble_EX", k), 32'(bus.bubble_EX), 32'd1);
            tick();
            check_state($sformatf("stall%0d", k), 16'h0046, 16'h0A40, 16'h0046, 1'b1,
                        16'(2 + k), 1'b0);
            check($sformatf("stall%0d.rsaddr_ID", k), 32'(bus.rsaddr_ID), 32'd5);
            check($sformatf("stall%0d.rtaddr_ID", k), 32'(bus.rtaddr_ID), 32'd1);
        end
        bus.DataHazard = 1'b0;
        tick();
        check_state("resume", 16'h0048, 16'h1046, 16'h0048, 1'b1, 16'd4, 1'b0);

        // Three consecutive stalls trip the sticky alarm on the third edge.
        bus.DataHazard = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("run%0d.stall_cnt", k), 32'(bus.stall_cnt), 32'(4 + k));
            check($sformatf("run%0d.hazard_err", k), 32'(bus.hazard_err), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("run%0d.imem_addr", k), 32'(bus.imem_addr), 32'h0048);
        end
        bus.DataHazard = 1'b0;
        tick();
        tick();
        check_state("sticky", 16'h004C, 16'h104A, 16'h004C, 1'b1, 16'd7, 1'b1);

        // PC wrap: redirect to 16'hFFFE, then advance across the top of the address space.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'hFFFE;
        tick();
        check_state("wrap.br", 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 16'd7, 1'b1);
        bus.branch_taken = 1'b0;
        tick();
        check_state("wrap.adv", 16'h0000, 16'h0FFE, 16'h0000, 1'b1, 16'd7, 1'b1);

        // Reset asserted while a stall is in progress.
        bus.DataHazard = 1'b1;
        tick();
        check("pre_rst.stall_cnt", 32'(bus.stall_cnt), 32'd8);
        rst = 1'b1;
        tick();
        check_state("rst_stall", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        check("rst_stall.bubble_EX", 32'(bus.bubble_EX), 32'd0);
        check("rst_stall.rsaddr_ID", 32'(bus.rsaddr_ID), 32'd0);
        rst            = 1'b0;
        bus.DataHazard = 1'b0;
        tick();
        check_state("post_rst", 16'h0002, 16'h1000, 16'h0002, 1'b1, 16'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
